ds18b20_reader: RTL and testbench

- Single-drop 1-Wire master that periodically reads a DS18B20 temperature sensor.
- Converts the 12-bit two's-complement reading to a magnitude in 0.1 °C units plus a sign flag.
- temp_tenths feeds the display driver's 16-bit binary data input directly (max 1250, so it fits in 4 BCD digits).
- Sits between the board's DQ pin (external tristate/pull-up at top level) and the display path.

---
 rtl/ds18b20_reader_if.sv | 34 +++
 rtl/ds18b20_reader.sv | 196 +++++++++++++++++++
 tb/tb_ds18b20_reader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ds18b20_reader_if.sv
// Bus bundle between the DS18B20 reader and its environment.
// master = reader side, slave = sensor/display side.
interface ds18b20_reader_if;
    logic        enable;
    logic        dq_in;
    logic        dq_oe;
    logic [15:0] temp_tenths;
    logic        temp_neg;
    logic        valid;
    logic        presence_err;
    logic        busy;

    modport master (
        input  enable,
        input  dq_in,
        output dq_oe,
        output temp_tenths,
        output temp_neg,
        output valid,
        output presence_err,
        output busy
    );

    modport slave (
        output enable,
        output dq_in,
        input  dq_oe,
        input  temp_tenths,
        input  temp_neg,
        input  valid,
        input  presence_err,
        input  busy
    );
endinterface

// File: rtl/ds18b20_reader.sv
// 1-Wire master that periodically reads a DS18B20 and reports |T| in 0.1 degC plus sign.
// All bus timing is counted in microseconds from a free-running prescaler tick.
module ds18b20_reader #(
    parameter int unsigned CLKS_PER_US  = 4,
    parameter int unsigned CONV_WAIT_MS = 750
) (
    input  logic              i_clk,
    input  logic              i_reset,
    ds18b20_reader_if.master  io_bus
);

    localparam int unsigned WaitUs = CONV_WAIT_MS * 1000;
    localparam int unsigned CntW   = (WaitUs > 512) ? $clog2(WaitUs) : 9;
    localparam int unsigned PreW   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    localparam logic [PreW-1:0] PreLast    = PreW'(CLKS_PER_US - 1);
    localparam logic [CntW-1:0] RstLast    = CntW'(479);
    localparam logic [CntW-1:0] PresSample = CntW'(69);
    localparam logic [CntW-1:0] SlotLast   = CntW'(69);
    localparam logic [CntW-1:0] RxSample   = CntW'(14);
    localparam logic [CntW-1:0] ShortLow   = CntW'(6);
    localparam logic [CntW-1:0] LongLow    = CntW'(60);
    localparam logic [CntW-1:0] WaitLast   = CntW'(WaitUs - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StRstLow   = 3'd1;
    localparam logic [2:0] StRstPres  = 3'd2;
    localparam logic [2:0] StTx       = 3'd3;
    localparam logic [2:0] StConvWait = 3'd4;
    localparam logic [2:0] StRx       = 3'd5;
    localparam logic [2:0] StCalc     = 3'd6;
    localparam logic [2:0] StDone     = 3'd7;

    logic [PreW-1:0] r_pre;
    logic            r_dq_meta, r_dq_sync;
    logic [2:0]      r_state, w_state_d;
    logic [CntW-1:0] r_us_cnt, w_us_cnt_d;
    logic [3:0]      r_bit_cnt, w_bit_cnt_d;
    logic            r_phase_read, w_phase_d;
    logic [15:0]     r_raw, w_raw_d;
    logic [15:0]     r_temp, w_temp_d;
    logic            r_neg, w_neg_d;
    logic            r_perr, w_perr_d;
    logic            r_dq_oe, w_dq_oe_d;

    logic            w_us_tick;
    logic [15:0]     w_mag;
    logic [19:0]     w_prod;
    logic [15:0]     w_tenths;
    logic            w_unused_lsb;
    logic [7:0]      w_tx_byte_d;

    assign w_us_tick = (r_pre == PreLast);

    assign w_mag        = r_raw[15] ? (~r_raw + 16'd1) : r_raw;
    assign w_prod       = {4'd0, w_mag} * 20'd10;
    assign w_tenths     = w_prod[19:4];
    assign w_unused_lsb = ^w_prod[3:0];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pre     <= '0;
            r_dq_meta <= 1'b1;
            r_dq_sync <= 1'b1;
        end else begin
            r_pre     <= w_us_tick ? '0 : r_pre + 1'b1;
            r_dq_meta <= io_bus.dq_in;
            r_dq_sync <= r_dq_meta;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_us_cnt_d  = w_us_tick ? r_us_cnt + 1'b1 : r_us_cnt;
        w_bit_cnt_d = r_bit_cnt;
        w_phase_d   = r_phase_read;
        w_raw_d     = r_raw;
        w_temp_d    = r_temp;
        w_neg_d     = r_neg;
        w_perr_d    = r_perr;
        case (r_state)
            StIdle: begin
                w_us_cnt_d = '0;
                if (io_bus.enable && w_us_tick) begin
                    w_state_d   = StRstLow;
                    w_phase_d   = 1'b0;
                    w_bit_cnt_d = '0;
                end
            end
            StRstLow: begin
                if (w_us_tick && r_us_cnt == RstLast) begin
                    w_state_d  = StRstPres;
                    w_us_cnt_d = '0;
                end
            end
            StRstPres: begin
                if (w_us_tick && r_us_cnt == PresSample) begin
                    w_perr_d = r_dq_sync;
                    if (r_dq_sync) begin
                        w_state_d  = StIdle;
                        w_us_cnt_d = '0;
                    end
                end
                if (w_us_tick && r_us_cnt == RstLast) begin
                    w_state_d   = StTx;
                    w_us_cnt_d  = '0;
                    w_bit_cnt_d = '0;
                end
            end
            StTx: begin
                if (w_us_tick && r_us_cnt == SlotLast) begin
                    w_us_cnt_d  = '0;
                    w_bit_cnt_d = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 4'd15) begin
                        w_state_d = r_phase_read ? StRx : StConvWait;
                    end
                end
            end
            StConvWait: begin
                if (w_us_tick && r_us_cnt == WaitLast) begin
                    w_state_d  = StRstLow;
                    w_phase_d  = 1'b1;
                    w_us_cnt_d = '0;
                end
            end
            StRx: begin
                if (w_us_tick && r_us_cnt == RxSample) begin
                    w_raw_d = {r_dq_sync, r_raw[15:1]};
                end
                if (w_us_tick && r_us_cnt == SlotLast) begin
                    w_us_cnt_d  = '0;
                    w_bit_cnt_d = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 4'd15) begin
                        w_state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                w_temp_d  = w_tenths;
                w_neg_d   = r_raw[15] && (w_tenths != 16'd0);
                w_state_d = StDone;
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Drive decision uses next-state values so the registered pin lines up with the state.
    always_comb begin
        w_tx_byte_d = w_bit_cnt_d[3] ? (w_phase_d ? 8'hBE : 8'h44) : 8'hCC;
        w_dq_oe_d   = 1'b0;
        case (w_state_d)
            StRstLow: w_dq_oe_d = 1'b1;
            StTx:     w_dq_oe_d = (w_us_cnt_d < ShortLow) ||
                                  (!w_tx_byte_d[w_bit_cnt_d[2:0]] && (w_us_cnt_d < LongLow));
            StRx:     w_dq_oe_d = (w_us_cnt_d < ShortLow);
            default:  w_dq_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_us_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_phase_read <= 1'b0;
            r_raw        <= '0;
            r_temp       <= '0;
            r_neg        <= 1'b0;
            r_perr       <= 1'b0;
            r_dq_oe      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_us_cnt     <= w_us_cnt_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_phase_read <= w_phase_d;
            r_raw        <= w_raw_d;
            r_temp       <= w_temp_d;
            r_neg        <= w_neg_d;
            r_perr       <= w_perr_d;
            r_dq_oe      <= w_dq_oe_d;
        end
    end

    assign io_bus.dq_oe        = r_dq_oe;
    assign io_bus.temp_tenths  = r_temp;
    assign io_bus.temp_neg     = r_neg;
    assign io_bus.valid        = (r_state == StDone);
    assign io_bus.presence_err = r_perr;
    assign io_bus.busy         = (r_state != StIdle);

endmodule

// File: tb/tb_ds18b20_reader.sv
// Directed bench: two readers (4 and 1 clk/us) each with a behavioural DS18B20 and bus monitor.
module tb_ds18b20_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  en, rst_n, present;
    logic [15:0] raw [2];

    logic [1:0]  w_busy, w_valid, w_perr, w_neg, w_oe;
    logic [15:0] w_temp [2];
    int          m_rst [2], m_rst_len [2], m_bad [2], m_w1 [2], m_w0 [2], m_rd [2];
    int          m_valid [2], m_cur [2], m_per [2], m_per_prev [2];
    logic [31:0] m_bytes [2];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int Cpu = (g == 0) ? 4 : 1;

        ds18b20_reader_if u_bus ();

        logic        sen_pull = 1'b0;
        logic        prev_oe  = 1'b0;
        logic        pres     = 1'b0;
        logic [7:0]  wr_shift = '0;
        logic [15:0] raw_l;
        logic [31:0] byte_log = '0;
        int oe_len = 0, rel_cnt = -1, rd_hold = 0, bitpos = 0, cyc = 0, v_last = 0;
        int n_rst = 0, rst_len = 0, n_bad = 0, n_w1 = 0, n_w0 = 0, n_rd = 0, n_valid = 0;
        int per = 0, per_prev = 0;

        assign u_bus.enable = en[g];
        assign u_bus.dq_in  = ~(u_bus.dq_oe | sen_pull);

        ds18b20_reader #(
            .CLKS_PER_US  (Cpu),
            .CONV_WAIT_MS (1)
        ) u_dut (
            .i_clk   (clk),
            .i_reset (rst_n[g]),
            .io_bus  (u_bus)
        );

        assign w_busy[g]     = u_bus.busy;
        assign w_valid[g]    = u_bus.valid;
        assign w_perr[g]     = u_bus.presence_err;
        assign w_neg[g]      = u_bus.temp_neg;
        assign w_oe[g]       = u_bus.dq_oe;
        assign w_temp[g]     = u_bus.temp_tenths;
        assign m_rst[g]      = n_rst;
        assign m_rst_len[g]  = rst_len;
        assign m_bad[g]      = n_bad;
        assign m_w1[g]       = n_w1;
        assign m_w0[g]       = n_w0;
        assign m_rd[g]       = n_rd;
        assign m_valid[g]    = n_valid;
        assign m_cur[g]      = oe_len;
        assign m_per[g]      = per;
        assign m_per_prev[g] = per_prev;
        assign m_bytes[g]    = byte_log;

        // Sensor model and low-pulse classifier, evaluated once per clock on the falling edge.
        initial forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (!rst_n[g]) begin
                prev_oe  = 1'b0;
                oe_len   = 0;
                rel_cnt  = -1;
                rd_hold  = 0;
                bitpos   = 0;
                sen_pull = 1'b0;
            end else begin
                raw_l = raw[g];
                if (u_bus.dq_oe && !prev_oe && bitpos >= 16 && bitpos < 32) begin
                    if (!raw_l[bitpos[3:0]]) rd_hold = 30 * Cpu;
                end
                if (u_bus.dq_oe) oe_len = oe_len + 1;
                if (!u_bus.dq_oe && prev_oe) begin
                    if (oe_len == 480 * Cpu) begin
                        n_rst   = n_rst + 1;
                        rst_len = oe_len;
                        bitpos  = 0;
                        rel_cnt = 0;
                    end else if (bitpos < 16 && (oe_len == 6 * Cpu || oe_len == 60 * Cpu)) begin
                        wr_shift = {(oe_len == 6 * Cpu), wr_shift[7:1]};
                        if (oe_len == 6 * Cpu) n_w1 = n_w1 + 1;
                        else n_w0 = n_w0 + 1;
                        if (bitpos[2:0] == 3'd7) byte_log = {byte_log[23:0], wr_shift};
                        bitpos = bitpos + 1;
                    end else if (bitpos >= 16 && oe_len == 6 * Cpu) begin
                        n_rd   = n_rd + 1;
                        bitpos = bitpos + 1;
                    end else begin
                        n_bad = n_bad + 1;
                    end
                    oe_len = 0;
                end
                pres = 1'b0;
                if (rel_cnt >= 0) begin
                    pres    = present[g] && rel_cnt >= 20 * Cpu && rel_cnt < 140 * Cpu;
                    rel_cnt = rel_cnt + 1;
                    if (rel_cnt >= 300 * Cpu) rel_cnt = -1;
                end
                sen_pull = pres | (rd_hold > 0);
                if (rd_hold > 0) rd_hold = rd_hold - 1;
                prev_oe = u_bus.dq_oe;
            end
            if (u_bus.valid) begin
                n_valid = n_valid + 1;
                if (v_last > 0) begin
                    per_prev = per;
                    per      = cyc - v_last;
                end
                v_last = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input int g, input logic lvl, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (w_busy[g] == lvl) break;
            step();
        end
        check(tag, {31'd0, w_busy[g]}, {31'd0, lvl});
    endtask

    task automatic run_cycle(input int g, input int budget, input string tag);
        en[g] = 1'b1;
        wait_busy(g, 1'b1, 64, {tag, "_busy_rise"});
        en[g] = 1'b0;
        wait_busy(g, 1'b0, budget, {tag, "_busy_fall"});
    endtask

    int r0, v0;

    initial begin
        en      = 2'b00;
        rst_n   = 2'b00;
        present = 2'b11;
        raw[0]  = 16'h0191;
        raw[1]  = 16'hFF5E;
        repeat (5) step();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst%0d_oe", g), {31'd0, w_oe[g]}, 0);
            check($sformatf("rst%0d_busy", g), {31'd0, w_busy[g]}, 0);
            check($sformatf("rst%0d_valid", g), {31'd0, w_valid[g]}, 0);
            check($sformatf("rst%0d_perr", g), {31'd0, w_perr[g]}, 0);
            check($sformatf("rst%0d_neg", g), {31'd0, w_neg[g]}, 0);
            check($sformatf("rst%0d_temp", g), {16'd0, w_temp[g]}, 0);
        end
        rst_n = 2'b11;
        step();

        // +25.0625 degC with full bus-timing decode at 4 clk/us
        run_cycle(0, 40000, "a");
        check("a_temp", {16'd0, w_temp[0]}, 250);
        check("a_neg", {31'd0, w_neg[0]}, 0);
        check("a_perr", {31'd0, w_perr[0]}, 0);
        check("a_valid_cnt", m_valid[0], 1);
        check("a_bytes", m_bytes[0], 32'hCC44CCBE);
        check("a_rst_cnt", m_rst[0], 2);
        check("a_rst_len", m_rst_len[0], 1920);
        check("a_w1_cnt", m_w1[0], 16);
        check("a_w0_cnt", m_w0[0], 16);
        check("a_rd_cnt", m_rd[0], 16);
        check("a_bad", m_bad[0], 0);

        // Async reset halfway through the first write-0 slot
        r0 = m_rst[0];
        en[0] = 1'b1;
        wait_busy(0, 1'b1, 64, "b_busy_rise");
        en[0] = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (m_rst[0] != r0 && w_oe[0] && m_cur[0] == 120) break;
        end
        check("b_mid_slot", m_cur[0], 120);
        rst_n[0] = 1'b0;
        #1;
        check("b_async_oe", {31'd0, w_oe[0]}, 0);
        check("b_async_busy", {31'd0, w_busy[0]}, 0);
        check("b_async_temp", {16'd0, w_temp[0]}, 0);
        step();
        rst_n[0] = 1'b1;
        step();
        r0 = m_rst[0];
        en[0] = 1'b1;
        wait_busy(0, 1'b1, 64, "b2_busy_rise");
        en[0] = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (m_rst[0] != r0) break;
        end
        check("b_rst_cnt", m_rst[0] - r0, 1);
        check("b_rst_len", m_rst_len[0], 1920);
        check("b_bad", m_bad[0], 0);
        rst_n[0] = 1'b0;

        // -10.125 degC at 1 clk/us
        run_cycle(1, 10000, "c");
        check("c_temp", {16'd0, w_temp[1]}, 101);
        check("c_neg", {31'd0, w_neg[1]}, 1);
        check("c_perr", {31'd0, w_perr[1]}, 0);
        check("c_valid_cnt", m_valid[1], 1);

        // No presence: sticky error, outputs held, no valid
        present[1] = 1'b0;
        v0 = m_valid[1];
        run_cycle(1, 2000, "np");
        check("np_perr", {31'd0, w_perr[1]}, 1);
        check("np_temp", {16'd0, w_temp[1]}, 101);
        check("np_neg", {31'd0, w_neg[1]}, 1);
        check("np_valid_cnt", m_valid[1] - v0, 0);

        // +125 degC, presence restored clears the error
        present[1] = 1'b1;
        raw[1] = 16'h07D0;
        v0 = m_valid[1];
        run_cycle(1, 10000, "d");
        check("d_perr", {31'd0, w_perr[1]}, 0);
        check("d_temp", {16'd0, w_temp[1]}, 1250);
        check("d_neg", {31'd0, w_neg[1]}, 0);
        check("d_valid_cnt", m_valid[1] - v0, 1);

        // -0.0625 degC with enable held; a mid-cycle enable glitch must not matter
        raw[1] = 16'hFFFF;
        v0 = m_valid[1];
        en[1] = 1'b1;
        for (int i = 0; i < 25000; i++) begin
            step();
            if (i == 9000) en[1] = 1'b0;
            if (i == 9010) en[1] = 1'b1;
            if (m_valid[1] - v0 >= 3) break;
        end
        check("e_valid_cnt", m_valid[1] - v0, 3);
        check("e_period_const", m_per[1], m_per_prev[1]);
        check("e_period", m_per[1], 6283);
        check("e_temp", {16'd0, w_temp[1]}, 0);
        check("e_neg", {31'd0, w_neg[1]}, 0);
        en[1] = 1'b0;
        wait_busy(1, 1'b0, 10000, "e_busy_fall");
        check("e_bad", m_bad[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
